// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg                                                          |
// | Shared constants for the multi-port register file.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package regfile_pkg;
  localparam int c_DATA_W       = 32;
  localparam int c_ADDR_W       = 5;
  localparam int c_ZERO_ADDR    = 0;
  // Write lane that wins when both lanes hit the same register.
  localparam int c_HI_PRIO_LANE = 1;
endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_scoreboard                                                   |
// | Per-register pending bits: set by reservations, cleared by writes.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = c_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RegWre0,
  input  logic [ADDR_W-1:0]       WriteReg0,
  input  logic                    RegWre1,
  input  logic [ADDR_W-1:0]       WriteReg1,
  input  logic                    RsvEn,
  input  logic [ADDR_W-1:0]       RsvReg,
  output logic [(1<<ADDR_W)-1:0]  Pending,
  output logic                    AnyPending
);
  localparam int                 c_DEPTH = 1 << ADDR_W;
  localparam logic [c_DEPTH-1:0] c_ONE   = c_DEPTH'(1);

  logic [c_DEPTH-1:0] r_pending;
  logic [c_DEPTH-1:0] w_clr;
  logic [c_DEPTH-1:0] w_set;
  logic [c_DEPTH-1:0] w_next;

  // Set after clear: a same-cycle reservation belongs to a newer producer.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (RegWre0) w_clr = w_clr | (c_ONE << WriteReg0);
    if (RegWre1) w_clr = w_clr | (c_ONE << WriteReg1);
    if (RsvEn)   w_set = c_ONE << RsvReg;
    w_next = (r_pending & ~w_clr) | w_set;
    if (ZERO_REG != 0) w_next[c_ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_pending <= '0;
    else     r_pending <= w_next;
  end

  assign Pending    = r_pending;
  assign AnyPending = |r_pending;
endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_multiport                                                    |
// | Dual-write, NUM_RD-read register file with bypass and pending bits.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = c_DATA_W,
  parameter int ADDR_W   = c_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RegWre0,
  input  logic [ADDR_W-1:0]         WriteReg0,
  input  logic [DATA_W-1:0]         WriteData0,
  input  logic                      RegWre1,
  input  logic [ADDR_W-1:0]         WriteReg1,
  input  logic [DATA_W-1:0]         WriteData1,
  input  logic [NUM_RD*ADDR_W-1:0]  ReadReg,
  output logic [NUM_RD*DATA_W-1:0]  ReadData,
  output logic [NUM_RD-1:0]         ReadPending,
  input  logic                      RsvEn,
  input  logic [ADDR_W-1:0]         RsvReg,
  output logic                      AnyPending
);
  localparam int                c_DEPTH        = 1 << ADDR_W;
  localparam int                c_LO_PRIO_LANE = 1 - c_HI_PRIO_LANE;
  localparam logic [ADDR_W-1:0] c_ZERO         = ADDR_W'(c_ZERO_ADDR);

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] w_pending;

  logic              w_laneWe    [2];
  logic              w_laneMemWe [2];
  logic [ADDR_W-1:0] w_laneAddr  [2];
  logic [DATA_W-1:0] w_laneData  [2];

  // Lanes are masked during reset so nothing is forwarded while RST is high.
  always_comb begin
    w_laneWe[0]   = RegWre0 & ~RST;
    w_laneWe[1]   = RegWre1 & ~RST;
    w_laneAddr[0] = WriteReg0;
    w_laneAddr[1] = WriteReg1;
    w_laneData[0] = WriteData0;
    w_laneData[1] = WriteData1;
    for (int l = 0; l < 2; l++) begin
      w_laneMemWe[l] = w_laneWe[l] && !(ZERO_REG != 0 && w_laneAddr[l] == c_ZERO);
    end
  end

  // Low-priority lane is written first so the high-priority lane overrides it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < c_DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_laneMemWe[c_LO_PRIO_LANE])
        r_mem[w_laneAddr[c_LO_PRIO_LANE]] <= w_laneData[c_LO_PRIO_LANE];
      if (w_laneMemWe[c_HI_PRIO_LANE])
        r_mem[w_laneAddr[c_HI_PRIO_LANE]] <= w_laneData[c_HI_PRIO_LANE];
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .CLK        (CLK),
    .RST        (RST),
    .RegWre0    (RegWre0),
    .WriteReg0  (WriteReg0),
    .RegWre1    (RegWre1),
    .WriteReg1  (WriteReg1),
    .RsvEn      (RsvEn),
    .RsvReg     (RsvReg),
    .Pending    (w_pending),
    .AnyPending (AnyPending)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_pend;

    assign w_addr = ReadReg[i*ADDR_W +: ADDR_W];

    // Zero register overrides bypass; forwarded data is never pending.
    always_comb begin
      w_data = r_mem[w_addr];
      w_pend = w_pending[w_addr];
      if (BYPASS != 0) begin
        if (w_laneWe[c_HI_PRIO_LANE] && w_laneAddr[c_HI_PRIO_LANE] == w_addr) begin
          w_data = w_laneData[c_HI_PRIO_LANE];
          w_pend = 1'b0;
        end else if (w_laneWe[c_LO_PRIO_LANE] && w_laneAddr[c_LO_PRIO_LANE] == w_addr) begin
          w_data = w_laneData[c_LO_PRIO_LANE];
          w_pend = 1'b0;
        end
      end
      if (ZERO_REG != 0 && w_addr == c_ZERO) begin
        w_data = '0;
        w_pend = 1'b0;
      end
    end

    assign ReadData[i*DATA_W +: DATA_W] = w_data;
    assign ReadPending[i]               = w_pend;
  end
endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_multiport                                                 |
// | Scoreboard bench for regfile_multiport (bypass and no-bypass copies).|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_regfile_multiport;
  logic        CLK = 1'b0;
  logic        RST;
  logic        RegWre0, RegWre1, RsvEn;
  logic [4:0]  WriteReg0, WriteReg1, RsvReg;
  logic [31:0] WriteData0, WriteData1;
  logic [9:0]  ReadReg;
  logic [63:0] readData, readDataNb;
  logic [1:0]  readPending, readPendingNb;
  logic        anyPending, anyPendingNb;

  int          nTests = 0;
  int          nFail  = 0;
  logic [31:0] expQ[$];
  logic [31:0] e;
  logic [31:0] model [32];

  always #5 CLK = ~CLK;

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .CLK(CLK), .RST(RST),
    .RegWre0(RegWre0), .WriteReg0(WriteReg0), .WriteData0(WriteData0),
    .RegWre1(RegWre1), .WriteReg1(WriteReg1), .WriteData1(WriteData1),
    .ReadReg(ReadReg), .ReadData(readData), .ReadPending(readPending),
    .RsvEn(RsvEn), .RsvReg(RsvReg), .AnyPending(anyPending)
  );

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dutNb (
    .CLK(CLK), .RST(RST),
    .RegWre0(RegWre0), .WriteReg0(WriteReg0), .WriteData0(WriteData0),
    .RegWre1(RegWre1), .WriteReg1(WriteReg1), .WriteData1(WriteData1),
    .ReadReg(ReadReg), .ReadData(readDataNb), .ReadPending(readPendingNb),
    .RsvEn(RsvEn), .RsvReg(RsvReg), .AnyPending(anyPendingNb)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RegWre0 = 1'b0; WriteReg0 = '0; WriteData0 = '0;
    RegWre1 = 1'b0; WriteReg1 = '0; WriteData1 = '0;
    RsvEn   = 1'b0; RsvReg    = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1; idle(); ReadReg = {5'd6, 5'd5};
    expQ.push_back(32'h0); expQ.push_back(32'h0); expQ.push_back(32'h0);
    #2;
    e = expQ.pop_front(); nTests++;
    if (readData[31:0] !== e) begin nFail++; $display("FAIL por_data: got %h expected %h", readData[31:0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, anyPending} !== e) begin nFail++; $display("FAIL por_any: got %h expected %h", anyPending, e); end
    e = expQ.pop_front(); nTests++;
    if ({30'b0, readPending} !== e) begin nFail++; $display("FAIL por_pend: got %h expected %h", readPending, e); end
    tick(); RST = 1'b0;
    tick();
    RegWre0 = 1'b1; WriteReg0 = 5'd5; WriteData0 = 32'hDEADBEEF;
    RsvEn = 1'b1; RsvReg = 5'd6;
    tick(); idle();
    expQ.push_back(32'hDEADBEEF); expQ.push_back(32'h1);
    #1;
    e = expQ.pop_front(); nTests++;
    if (readData[31:0] !== e) begin nFail++; $display("FAIL pre_reset_r5: got %h expected %h", readData[31:0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, anyPending} !== e) begin nFail++; $display("FAIL pre_reset_any: got %h expected %h", anyPending, e); end
    // Mid-cycle async reset with a write that must be neither forwarded nor stored.
    RST = 1'b1; RegWre0 = 1'b1; WriteReg0 = 5'd5; WriteData0 = 32'h77;
    expQ.push_back(32'h0); expQ.push_back(32'h0); expQ.push_back(32'h0);
    #1;
    e = expQ.pop_front(); nTests++;
    if (readData[31:0] !== e) begin nFail++; $display("FAIL reset_r5: got %h expected %h", readData[31:0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, anyPending} !== e) begin nFail++; $display("FAIL reset_any: got %h expected %h", anyPending, e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, readPending[1]} !== e) begin nFail++; $display("FAIL reset_pend_r6: got %h expected %h", readPending[1], e); end
    tick(); RST = 1'b0; idle();
    expQ.push_back(32'h0);
    #1;
    e = expQ.pop_front(); nTests++;
    if (readData[31:0] !== e) begin nFail++; $display("FAIL reset_write_ignored: got %h expected %h", readData[31:0], e); end
  endtask

  task automatic test_dual_write();
    idle(); ReadReg = {5'd0, 5'd3};
    RegWre0 = 1'b1; WriteReg0 = 5'd3; WriteData0 = 32'h11;
    RegWre1 = 1'b1; WriteReg1 = 5'd3; WriteData1 = 32'h22;
    expQ.push_back(32'h22);
    #1;
    e = expQ.pop_front(); nTests++;
    if (readData[31:0] !== e) begin nFail++; $display("FAIL dual_bypass: got %h expected %h", readData[31:0], e); end
    tick(); idle();
    expQ.push_back(32'h22); expQ.push_back(32'h22);
    #1;
    e = expQ.pop_front(); nTests++;
    if (readData[31:0] !== e) begin nFail++; $display("FAIL dual_stored: got %h expected %h", readData[31:0], e); end
    e = expQ.pop_front(); nTests++;
    if (readDataNb[31:0] !== e) begin nFail++; $display("FAIL dual_stored_nb: got %h expected %h", readDataNb[31:0], e); end
  endtask

  task automatic test_bypass();
    idle(); RegWre0 = 1'b1; WriteReg0 = 5'd7; WriteData0 = 32'hAAAA;
    tick(); idle();
    ReadReg = {5'd7, 5'd0};
    RegWre0 = 1'b1; WriteReg0 = 5'd7; WriteData0 = 32'h1234;
    expQ.push_back(32'h1234); expQ.push_back(32'hAAAA); expQ.push_back(32'h0);
    #1;
    e = expQ.pop_front(); nTests++;
    if (readData[63:32] !== e) begin nFail++; $display("FAIL bypass_p1: got %h expected %h", readData[63:32], e); end
    e = expQ.pop_front(); nTests++;
    if (readDataNb[63:32] !== e) begin nFail++; $display("FAIL nobypass_p1_old: got %h expected %h", readDataNb[63:32], e); end
    e = expQ.pop_front(); nTests++;
    if (readData[31:0] !== e) begin nFail++; $display("FAIL bypass_p0_r0: got %h expected %h", readData[31:0], e); end
    tick(); idle();
    expQ.push_back(32'h1234);
    #1;
    e = expQ.pop_front(); nTests++;
    if (readDataNb[63:32] !== e) begin nFail++; $display("FAIL nobypass_p1_new: got %h expected %h", readDataNb[63:32], e); end
  endtask

  task automatic test_zero();
    idle(); ReadReg = {5'd0, 5'd0};
    RegWre0 = 1'b1; WriteReg0 = 5'd0; WriteData0 = 32'hFFFF;
    RsvEn = 1'b1; RsvReg = 5'd0;
    expQ.push_back(32'h0);
    #1;
    e = expQ.pop_front(); nTests++;
    if (readData[31:0] !== e) begin nFail++; $display("FAIL zero_bypass: got %h expected %h", readData[31:0], e); end
    tick(); idle();
    expQ.push_back(32'h0); expQ.push_back(32'h0); expQ.push_back(32'h0); expQ.push_back(32'h0);
    #1;
    e = expQ.pop_front(); nTests++;
    if (readData[31:0] !== e) begin nFail++; $display("FAIL zero_data: got %h expected %h", readData[31:0], e); end
    e = expQ.pop_front(); nTests++;
    if (readDataNb[31:0] !== e) begin nFail++; $display("FAIL zero_data_nb: got %h expected %h", readDataNb[31:0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, readPending[0]} !== e) begin nFail++; $display("FAIL zero_pend: got %h expected %h", readPending[0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, anyPending} !== e) begin nFail++; $display("FAIL zero_any: got %h expected %h", anyPending, e); end
  endtask

  task automatic test_scoreboard();
    idle(); ReadReg = {5'd0, 5'd4};
    RsvEn = 1'b1; RsvReg = 5'd4;
    expQ.push_back(32'h0);
    #1;
    e = expQ.pop_front(); nTests++;
    if ({31'b0, readPending[0]} !== e) begin nFail++; $display("FAIL rsv_latency: got %h expected %h", readPending[0], e); end
    tick(); idle();
    expQ.push_back(32'h1); expQ.push_back(32'h1);
    #1;
    e = expQ.pop_front(); nTests++;
    if ({31'b0, readPending[0]} !== e) begin nFail++; $display("FAIL rsv_pend: got %h expected %h", readPending[0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, anyPending} !== e) begin nFail++; $display("FAIL rsv_any: got %h expected %h", anyPending, e); end
    RegWre1 = 1'b1; WriteReg1 = 5'd4; WriteData1 = 32'h55;
    expQ.push_back(32'h0); expQ.push_back(32'h1); expQ.push_back(32'h1); expQ.push_back(32'h55);
    #1;
    e = expQ.pop_front(); nTests++;
    if ({31'b0, readPending[0]} !== e) begin nFail++; $display("FAIL wb_pend_bypass: got %h expected %h", readPending[0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, readPendingNb[0]} !== e) begin nFail++; $display("FAIL wb_pend_nb: got %h expected %h", readPendingNb[0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, anyPending} !== e) begin nFail++; $display("FAIL wb_any_during: got %h expected %h", anyPending, e); end
    e = expQ.pop_front(); nTests++;
    if (readData[31:0] !== e) begin nFail++; $display("FAIL wb_data_bypass: got %h expected %h", readData[31:0], e); end
    tick(); idle();
    expQ.push_back(32'h0); expQ.push_back(32'h0); expQ.push_back(32'h55);
    #1;
    e = expQ.pop_front(); nTests++;
    if ({31'b0, readPending[0]} !== e) begin nFail++; $display("FAIL wb_pend_after: got %h expected %h", readPending[0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, anyPending} !== e) begin nFail++; $display("FAIL wb_any_after: got %h expected %h", anyPending, e); end
    e = expQ.pop_front(); nTests++;
    if (readDataNb[31:0] !== e) begin nFail++; $display("FAIL wb_data_after: got %h expected %h", readDataNb[31:0], e); end
  endtask

  task automatic test_collision();
    idle(); ReadReg = {5'd0, 5'd9};
    RsvEn = 1'b1; RsvReg = 5'd9;
    RegWre0 = 1'b1; WriteReg0 = 5'd9; WriteData0 = 32'h9;
    tick(); idle();
    expQ.push_back(32'h9); expQ.push_back(32'h1); expQ.push_back(32'h1);
    #1;
    e = expQ.pop_front(); nTests++;
    if (readDataNb[31:0] !== e) begin nFail++; $display("FAIL coll_data: got %h expected %h", readDataNb[31:0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, readPending[0]} !== e) begin nFail++; $display("FAIL coll_pend: got %h expected %h", readPending[0], e); end
    e = expQ.pop_front(); nTests++;
    if ({31'b0, anyPending} !== e) begin nFail++; $display("FAIL coll_any: got %h expected %h", anyPending, e); end
    RegWre1 = 1'b1; WriteReg1 = 5'd9; WriteData1 = 32'h99;
    tick(); idle();
    expQ.push_back(32'h0);
    #1;
    e = expQ.pop_front(); nTests++;
    if ({31'b0, anyPending} !== e) begin nFail++; $display("FAIL coll_cleared: got %h expected %h", anyPending, e); end
  endtask

  task automatic test_back_to_back();
    idle();
    #2; RST = 1'b1; #1; RST = 1'b0;
    for (int k = 0; k < 32; k++) model[k] = '0;
    for (int c = 0; c < 24; c++) begin
      tick();
      RegWre0 = 1'($urandom_range(0, 1)); WriteReg0 = 5'($urandom_range(0, 31)); WriteData0 = $urandom;
      RegWre1 = 1'($urandom_range(0, 1)); WriteReg1 = 5'($urandom_range(0, 31)); WriteData1 = $urandom;
      if (c % 4 == 0) begin RegWre1 = 1'b1; WriteReg1 = WriteReg0; RegWre0 = 1'b1; end
      if (RegWre0 && WriteReg0 != 5'd0) model[WriteReg0] = WriteData0;
      if (RegWre1 && WriteReg1 != 5'd0) model[WriteReg1] = WriteData1;
    end
    tick(); idle();
    for (int k = 0; k < 32; k++) begin
      ReadReg = {5'(k ^ 1), 5'(k)};
      expQ.push_back(model[k]); expQ.push_back(model[k ^ 1]);
      #1;
      e = expQ.pop_front(); nTests++;
      if (readData[31:0] !== e) begin nFail++; $display("FAIL b2b_p0 r%0d: got %h expected %h", k, readData[31:0], e); end
      e = expQ.pop_front(); nTests++;
      if (readDataNb[63:32] !== e) begin nFail++; $display("FAIL b2b_p1 r%0d: got %h expected %h", k ^ 1, readDataNb[63:32], e); end
    end
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_collision();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
`default_nettype wire
